mem_port_arbiter: RTL and testbench

- Shares the single unified 16-bit instruction/data memory of the multicycle NITCRisc24 core between two requesters.
- Port 0 is the core's memory interface, used in its FETCH, MEMRD and MEMWR states. Port 1 is a DMA/program-loader port.
- Serialises one transaction at a time, drives the memory's enable, write, address and data lines, and returns read data with a single-cycle acknowledge.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified instruction/data memory between the core (port 0,
//   cpu_*) and a DMA/program-loader (port 1, dma_*). One transaction at a
//   time; every output comes from a flop.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   cpu_req/we/adr/wd   port 0 request, held until cpu_ack
//   cpu_ack, cpu_rd     port 0 one-cycle completion pulse and read data
//   dma_*               same as cpu_* for port 1
//   mem_en/we/adr/wd    memory strobe (one cycle per transaction) and fields
//   mem_rd              memory read data, valid RD_LAT cycles after mem_en
//   busy                high whenever the arbiter is not idle
//   owner               port of the current/most recent transaction (1 = dma)
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner's fields
// ISSUE | mem_en strobe with the latched fields
// WAIT  | read in flight; counter runs down to the mem_rd capture cycle
// RESP  | owner's ack pulse; last-served updated

module mem_port_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1,
    parameter int RR     = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rd,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_adr,
    input  logic [DW-1:0] dma_wd,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rd,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          mem_en_q, mem_en_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] cpu_rd_q, cpu_rd_d;
    logic [DW-1:0] dma_rd_q, dma_rd_d;
    logic          busy_q, busy_d;
    logic          grant_dma;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;   // dma counted as last served: cpu wins the first tie
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wd_q      <= '0;
            cnt_q     <= '0;
            mem_en_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            cpu_rd_q  <= '0;
            dma_rd_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wd_q      <= wd_d;
            cnt_q     <= cnt_d;
            mem_en_q  <= mem_en_d;
            cpu_ack_q <= cpu_ack_d;
            dma_ack_q <= dma_ack_d;
            cpu_rd_q  <= cpu_rd_d;
            dma_rd_q  <= dma_rd_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wd_d      = wd_q;
        cnt_d     = cnt_q;
        mem_en_d  = 1'b0;
        cpu_ack_d = 1'b0;
        dma_ack_d = 1'b0;
        cpu_rd_d  = cpu_rd_q;
        dma_rd_d  = dma_rd_q;

        // dma wins alone, or on a tie in round-robin mode when cpu went last
        grant_dma = dma_req && (!cpu_req || ((RR != 0) && !last_q));

        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d  = grant_dma;
                    we_d     = grant_dma ? dma_we  : cpu_we;
                    adr_d    = grant_dma ? dma_adr : cpu_adr;
                    wd_d     = grant_dma ? dma_wd  : cpu_wd;
                    mem_en_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    cpu_ack_d = !owner_q;
                    dma_ack_d = owner_q;
                    state_d   = RESP;
                end else begin
                    cnt_d   = 2'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (owner_q) begin
                        dma_rd_d = mem_rd;
                    end else begin
                        cpu_rd_d = mem_rd;
                    end
                    cpu_ack_d = !owner_q;
                    dma_ack_d = owner_q;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                // no re-arbitration here: the served req is still high
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign cpu_ack = cpu_ack_q;
    assign dma_ack = dma_ack_q;
    assign cpu_rd  = cpu_rd_q;
    assign dma_rd  = dma_rd_q;
    assign mem_en  = mem_en_q;
    assign mem_we  = we_q;
    assign mem_adr = adr_q;
    assign mem_wd  = wd_q;
    assign busy    = busy_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances share one stimulus:
//   g=0: RR=1, RD_LAT=1   g=1: RR=1, RD_LAT=3   g=2: RR=0, RD_LAT=4
// Each instance has a memory model that drives mem_rd with valid data only
// in the single cycle RD_LAT after its mem_en cycle (16'hDEAD otherwise).

module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_adr, cpu_wd, dma_adr, dma_wd;

    logic [2:0]        cpu_ack, dma_ack, mem_en, mem_we, busy, owner;
    logic [2:0][15:0]  cpu_rd, dma_rd, mem_adr, mem_wd, mem_rd;

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mf(input logic [15:0] a);
        return (a == 16'h0020) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        localparam int R = (g == 2) ? 0 : 1;

        logic [3:0]       v = '0;
        logic [3:0][15:0] a = '0;

        always @(posedge clk) begin
            v <= {v[2:0], mem_en[g]};
            a <= {a[2:0], mem_adr[g]};
        end

        assign mem_rd[g] = v[L-1] ? mf(a[L-1]) : 16'hDEAD;

        mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(L), .RR(R)) u_dut (
            .clk     (clk),
            .reset   (reset),
            .cpu_req (cpu_req),
            .cpu_we  (cpu_we),
            .cpu_adr (cpu_adr),
            .cpu_wd  (cpu_wd),
            .cpu_ack (cpu_ack[g]),
            .cpu_rd  (cpu_rd[g]),
            .dma_req (dma_req),
            .dma_we  (dma_we),
            .dma_adr (dma_adr),
            .dma_wd  (dma_wd),
            .dma_ack (dma_ack[g]),
            .dma_rd  (dma_rd[g]),
            .mem_en  (mem_en[g]),
            .mem_we  (mem_we[g]),
            .mem_adr (mem_adr[g]),
            .mem_wd  (mem_wd[g]),
            .mem_rd  (mem_rd[g]),
            .busy    (busy[g]),
            .owner   (owner[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wd = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_adr = '0; dma_wd = '0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        do_reset();

        // reset values
        for (int g = 0; g < 3; g++) begin
            chk1 ($sformatf("rst_busy%0d", g),    busy[g],    1'b0);
            chk1 ($sformatf("rst_owner%0d", g),   owner[g],   1'b0);
            chk1 ($sformatf("rst_mem_en%0d", g),  mem_en[g],  1'b0);
            chk1 ($sformatf("rst_cpu_ack%0d", g), cpu_ack[g], 1'b0);
            chk16($sformatf("rst_mem_adr%0d", g), mem_adr[g], 16'h0000);
            chk16($sformatf("rst_cpu_rd%0d", g),  cpu_rd[g],  16'h0000);
        end

        // single cpu write, then back-to-back second write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0010; cpu_wd = 16'hBEEF;
        step();                                  // cycle 1
        chk1 ("wr_mem_en_c1",  mem_en[0],  1'b1);
        chk1 ("wr_mem_we_c1",  mem_we[0],  1'b1);
        chk16("wr_mem_adr_c1", mem_adr[0], 16'h0010);
        chk16("wr_mem_wd_c1",  mem_wd[0],  16'hBEEF);
        chk1 ("wr_busy_c1",    busy[0],    1'b1);
        chk1 ("wr_ack_c1",     cpu_ack[0], 1'b0);
        step();                                  // cycle 2
        chk1 ("wr_ack_c2",     cpu_ack[0], 1'b1);
        chk1 ("wr_mem_en_c2",  mem_en[0],  1'b0);
        chk1 ("wr_busy_c2",    busy[0],    1'b1);
        chk1 ("wr_dma_ack_c2", dma_ack[0], 1'b0);
        step();                                  // cycle 3 (IDLE)
        chk1 ("wr_busy_c3",    busy[0],    1'b0);
        chk1 ("wr_ack_c3",     cpu_ack[0], 1'b0);
        cpu_adr = 16'h0011; cpu_wd = 16'hCAFE;
        step();                                  // cycle 4
        chk1 ("b2b_mem_en_c4",  mem_en[0],  1'b1);
        chk16("b2b_mem_adr_c4", mem_adr[0], 16'h0011);
        chk16("b2b_mem_wd_c4",  mem_wd[0],  16'hCAFE);
        step();                                  // cycle 5
        chk1 ("b2b_ack_c5",     cpu_ack[0], 1'b1);
        cpu_req = 1'b0;
        step();                                  // cycle 6
        chk1 ("b2b_ack_c6",     cpu_ack[0], 1'b0);
        chk1 ("b2b_mem_en_c6",  mem_en[0],  1'b0);
        step();                                  // cycle 7
        chk1 ("b2b_mem_en_c7",  mem_en[0],  1'b0);
        chk1 ("b2b_busy_c7",    busy[0],    1'b0);
        chk16("b2b_adr_hold_c7", mem_adr[0], 16'h0011);

        // single dma read
        do_reset();
        dma_req = 1'b1; dma_we = 1'b0; dma_adr = 16'h0020;
        step();                                  // cycle 1
        chk1 ("dr_mem_en_c1",  mem_en[1],  1'b1);
        chk1 ("dr_mem_we_c1",  mem_we[1],  1'b0);
        chk16("dr_mem_adr_c1", mem_adr[1], 16'h0020);
        chk1 ("dr_owner_c1",   owner[1],   1'b1);
        step();                                  // cycle 2
        chk1 ("dr_busy_c2",    busy[1],    1'b1);
        chk1 ("dr_ack_c2",     dma_ack[1], 1'b0);
        step();                                  // cycle 3
        chk1 ("dr_l1_ack_c3",  dma_ack[0], 1'b1);
        chk16("dr_l1_rd_c3",   dma_rd[0],  16'h1234);
        chk1 ("dr_ack_c3",     dma_ack[1], 1'b0);
        step();                                  // cycle 4
        chk1 ("dr_ack_c4",     dma_ack[1], 1'b0);
        step();                                  // cycle 5
        chk1 ("dr_ack_c5",     dma_ack[1], 1'b1);
        chk16("dr_rd_c5",      dma_rd[1],  16'h1234);
        chk16("dr_cpu_rd_c5",  cpu_rd[1],  16'h0000);
        chk1 ("dr_owner_c5",   owner[1],   1'b1);
        chk1 ("dr_cpu_ack_c5", cpu_ack[1], 1'b0);
        dma_req = 1'b0;
        step();                                  // cycle 6
        chk1 ("dr_ack_c6",     dma_ack[1], 1'b0);
        chk1 ("dr_busy_c6",    busy[1],    1'b0);

        // continuous simultaneous reads: RR alternates, fixed priority starves dma
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0001;
        dma_req = 1'b1; dma_we = 1'b0; dma_adr = 16'h0002;
        for (int c = 1; c <= 16; c++) begin
            step();
            chk1($sformatf("rr_cpu_ack_c%0d", c), cpu_ack[0], (c == 3 || c == 11));
            chk1($sformatf("rr_dma_ack_c%0d", c), dma_ack[0], (c == 7 || c == 15));
            chk1($sformatf("rr_mem_en_c%0d", c),  mem_en[0],  (c % 4 == 1));
            chk1($sformatf("rr_owner_c%0d", c),   owner[0],   (((c - 1) / 4) % 2 == 1));
            chk1($sformatf("fp_cpu_ack_c%0d", c), cpu_ack[2], (c == 6 || c == 13));
            chk1($sformatf("fp_dma_ack_c%0d", c), dma_ack[2], 1'b0);
            if (c == 3) chk16("rr_cpu_rd_c3", cpu_rd[0], 16'hA5A4);
            if (c == 7) begin
                chk16("rr_dma_rd_c7",  dma_rd[0], 16'hA5A7);
                chk16("rr_cpu_keep_c7", cpu_rd[0], 16'hA5A4);
            end
            if (c == 13) chk16("fp_cpu_rd_c13", cpu_rd[2], 16'hA5A4);
        end
        cpu_req = 1'b0; dma_req = 1'b0;

        // reset in the middle of a read, then a fresh read with a mid-flight address change
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0030;
        step();                                  // cycle 1
        chk1 ("mr_mem_en_c1",  mem_en[2],  1'b1);
        chk16("mr_mem_adr_c1", mem_adr[2], 16'h0030);
        step();                                  // cycle 2
        step();                                  // cycle 3 (g=2 in WAIT, g=0 in RESP)
        chk1 ("mr_busy_c3",    busy[2],    1'b1);
        chk1 ("mr_l1_ack_c3",  cpu_ack[0], 1'b1);
        reset = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk1 ($sformatf("ar_busy%0d", g),    busy[g],    1'b0);
            chk1 ($sformatf("ar_cpu_ack%0d", g), cpu_ack[g], 1'b0);
            chk16($sformatf("ar_mem_adr%0d", g), mem_adr[g], 16'h0000);
            chk16($sformatf("ar_cpu_rd%0d", g),  cpu_rd[g],  16'h0000);
        end
        step();
        step();
        reset = 1'b1;                            // cpu_req still high: cycle 0
        step();                                  // cycle 1
        chk1 ("fr_mem_en_c1",  mem_en[2],  1'b1);
        chk16("fr_mem_adr_c1", mem_adr[2], 16'h0030);
        chk1 ("fr_l3_en_c1",   mem_en[1],  1'b1);
        step();                                  // cycle 2
        cpu_adr = 16'h0040;
        for (int c = 3; c <= 6; c++) begin
            step();
            chk1 ($sformatf("st_l3_ack_c%0d", c), cpu_ack[1], (c == 5));
            chk1 ($sformatf("st_l4_ack_c%0d", c), cpu_ack[2], (c == 6));
            chk16($sformatf("st_l3_adr_c%0d", c), mem_adr[1], 16'h0030);
            chk16($sformatf("st_l4_adr_c%0d", c), mem_adr[2], 16'h0030);
            if (c == 5) chk16("st_l3_rd_c5", cpu_rd[1], 16'hA595);
            if (c == 6) chk16("st_l4_rd_c6", cpu_rd[2], 16'hA595);
        end
        cpu_req = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
